// File: rtl/hh_sweep_scheduler.sv
// hh_sweep_scheduler
//   Shares one Hodgkin-Huxley update datapath across N neuron contexts.
//   Each tick sweeps neurons 0..N-1. Each neuron's membrane state and
//   stimulus go to the datapath through a start/done handshake. The
//   result is thresholded, written back, and spiking indices are queued
//   in a small event FIFO.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   tick                      start one sweep (ignored and flagged while busy)
//   stim_we/addr/data         stimulus register write, accepted in any state
//   dp_start                  one-cycle operand-valid pulse to the datapath
//   dp_idx/state/stim         operands, held stable until dp_done
//   dp_done, dp_next_state    datapath result
//   spk_valid/idx, spk_ready  spike event FIFO head and pop
//   busy, sweep_done          sweep in progress / one-cycle completion pulse
//   overrun                   sticky: spike dropped or tick missed
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no sweep running; waiting for tick
// S_ISSUE | dp_start high for neuron idx, operands valid
// S_WAIT  | operands held, waiting for dp_done for neuron idx
module hh_sweep_scheduler #(
  parameter int          N          = 4,
  parameter int unsigned THRESH     = 50,
  parameter int          FIFO_DEPTH = 4,
  localparam int         AW         = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          stim_we,
  input  logic [AW-1:0] stim_addr,
  input  logic [7:0]    stim_data,
  output logic          dp_start,
  output logic [AW-1:0] dp_idx,
  output logic [7:0]    dp_state,
  output logic [7:0]    dp_stim,
  input  logic          dp_done,
  input  logic [7:0]    dp_next_state,
  output logic          spk_valid,
  output logic [AW-1:0] spk_idx,
  input  logic          spk_ready,
  output logic          busy,
  output logic          sweep_done,
  output logic          overrun
);

  localparam int            FAW      = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [7:0]    THRESH_B = 8'(THRESH);
  localparam logic [FAW:0]  FULL_CNT = (FAW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [7:0]    state_mem [N];
  logic [7:0]    stim_mem  [N];

  logic [AW-1:0] fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0] wr_ptr, rd_ptr;
  logic [FAW:0]   count;

  logic done_ok, last, spike, load, push_ok, pop_ok, full;

  assign done_ok = (state == S_WAIT) && dp_done;
  assign last    = (idx == LAST_IDX);
  assign spike   = done_ok && (dp_next_state >= THRESH_B);
  // Operands for the next neuron are latched on the edge entering ISSUE.
  assign load    = ((state == S_IDLE) && tick) || (done_ok && !last);
  assign idx_nx  = (state == S_IDLE) ? '0 : idx + AW'(1);

  assign full    = (count == FULL_CNT);
  assign pop_ok  = spk_valid && spk_ready;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok = spike && (!full || pop_ok);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (tick) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (dp_done) state_nx = last ? S_IDLE : S_ISSUE;
      default: state_nx = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    dp_start = (state == S_ISSUE);
    busy     = (state != S_IDLE);
  end

  // neuron storage, operand latches, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      dp_state   <= '0;
      dp_stim    <= '0;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        state_mem[i] <= '0;
        stim_mem[i]  <= '0;
      end
    end else begin
      sweep_done <= done_ok && last;
      if ((tick && (state != S_IDLE)) || (spike && !push_ok))
        overrun <= 1'b1;
      if (stim_we)
        stim_mem[stim_addr] <= stim_data;
      if (done_ok)
        state_mem[idx] <= spike ? 8'd0 : dp_next_state;
      if (load) begin
        idx      <= idx_nx;
        dp_state <= state_mem[idx_nx];
        dp_stim  <= stim_mem[idx_nx];
      end
    end
  end

  assign dp_idx = idx;

  // spike event FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= idx;
        wr_ptr           <= wr_ptr + FAW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + FAW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (FAW + 1)'(1);
        2'b01:   count <= count - (FAW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign spk_valid = (count != '0);
  assign spk_idx   = fifo_mem[rd_ptr];

endmodule

// File: doc/hh_sweep_scheduler.md
# hh_sweep_scheduler

Time-multiplexes one shared Hodgkin-Huxley neuron update datapath across N neuron contexts. On each `tick` it sweeps all neurons in index order: it presents each neuron's membrane state and stimulus current to the datapath through a start/done handshake, applies threshold and reset to the returned state, and writes the result back. Spiking neuron indices are queued in a small event FIFO for downstream logic. It sits between the stimulus/configuration interface and the single HH update unit.

## Interface
- `N` — default 4 — number of neuron contexts; must be a power of 2, from 2 to 16. `AW = log2(N)`.
- `THRESH` — default 50 — unsigned 8-bit spike threshold.
- `FIFO_DEPTH` — default 4 — spike event FIFO depth; must be a power of 2, 2 or more.
- `clk` in 1 — single clock; all logic is on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `tick` in 1 — single-cycle request to start one sweep over all neurons.
- `stim_we` in 1 — stimulus register write enable.
- `stim_addr` in AW — neuron index for the stimulus write.
- `stim_data` in 8 — stimulus current value.
- `dp_start` out 1 — one-cycle pulse; the datapath operands are valid.
- `dp_idx` out AW — neuron index being updated.
- `dp_state` out 8 — latched membrane state of `dp_idx`.
- `dp_stim` out 8 — latched stimulus of `dp_idx`.
- `dp_done` in 1 — datapath result valid.
- `dp_next_state` in 8 — datapath result, unsigned.
- `spk_valid` out 1 — spike FIFO is non-empty.
- `spk_idx` out AW — index at the head of the spike FIFO.
- `spk_ready` in 1 — pop; the FIFO head is consumed when `spk_valid & spk_ready`.
- `busy` out 1 — a sweep is in progress.
- `sweep_done` out 1 — one-cycle pulse when a sweep completes.
- `overrun` out 1 — sticky flag: a spike was dropped or a tick was missed. Cleared only by `rst`.

## Operation
- Storage:
  - `state_mem[N]` (8-bit) and `stim_mem[N]` (8-bit); all entries reset to 0.
  - A `stim_we` write lands at the clock edge and is accepted in every FSM state.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - `tick` → ISSUE with `idx = 0`.
  - All other inputs are ignored apart from stim writes and FIFO pops.
- ISSUE (exactly one cycle):
  - `dp_start = 1`.
  - `dp_state`/`dp_stim` are captured from `state_mem[idx]`/`stim_mem[idx]` at the end of the previous cycle. A stim write to `idx` in the ISSUE cycle itself is not seen until the next sweep.
  - Next state is WAIT.
- WAIT:
  - Hold `dp_idx`, `dp_state` and `dp_stim` stable.
  - Wait for `dp_done`; there is no timeout.
  - On `dp_done`, with `r = dp_next_state`:
    - If `r >= THRESH`: write 0 to `state_mem[idx]` and push `idx` to the spike FIFO.
    - Otherwise: write `r` to `state_mem[idx]`.
  - Then: if `idx == N-1`, go to IDLE and pulse `sweep_done`; otherwise `idx++` and go to ISSUE.
- Comparison is unsigned 8-bit. No saturation is applied; the datapath owns arithmetic.
- Spike FIFO:
  - A push when full is dropped and sets `overrun`, unless a pop occurs in the same cycle, in which case the push is accepted.
  - A pop when empty has no effect.
  - Order is preserved, so indices appear ascending within a sweep.
- `tick` while `busy` is ignored and sets `overrun`.
- `dp_done` outside WAIT, including in the ISSUE cycle, is ignored.
- `rst` mid-sweep:
  - Aborts the sweep.
  - Returns all storage to reset values.
  - Drives `dp_start` low from the next cycle.
  - A `dp_done` arriving later is ignored, because the FSM is in IDLE.

## Timing
- Reset values of outputs:
  - `dp_start`, `spk_valid`, `busy`, `sweep_done` and `overrun` are 0.
  - `dp_idx`, `dp_state`, `dp_stim` and `spk_idx` are 0.
- `tick` sampled in cycle t → `dp_start` high in cycle t+1 with `dp_idx = 0`.
- `busy` is high from t+1 through the cycle in which the final `dp_done` is sampled.
- `dp_done` is honoured from the cycle after `dp_start` onward. Minimum service time is 2 cycles per neuron.
- A `dp_done` in cycle c:
  - The writeback is visible in `state_mem` at c+1.
  - The next neuron's `dp_start` is at c+1.
  - The pushed spike gives `spk_valid` at c+1 (when the FIFO was empty).
- `sweep_done` pulses in cycle c+1 after the last neuron's `dp_done`. `busy` is 0 in that cycle.
- Fastest sweep: `tick` at t → `sweep_done` at t+2N+1.
- A `tick` in the same cycle as `sweep_done` starts a new sweep and is not counted as an overrun.

## Test plan
- Reset, then N=4 with `dp_done` returned one cycle after each `dp_start`:
  - `tick` at cycle 10 → `dp_start` at cycles 11, 13, 15, 17 with idx 0..3.
  - `sweep_done` at 19; no spikes.
- Write stim 0x20 to neuron 2; the model returns `dp_state + dp_stim`:
  - After sweep 1, `dp_state` for neuron 2 in sweep 2 is 0x20.
  - In sweep 2 it reaches 0x40 ≥ 50, so neuron 2 spikes: `spk_idx = 2`, and `dp_state` for neuron 2 is 0 in sweep 3.
- All neurons return 60 with `spk_ready = 0` and `FIFO_DEPTH = 4`:
  - 4 events are queued, indices 0, 1, 2, 3, and `overrun` stays 0.
  - In the next sweep the first push (neuron 0) is dropped and `overrun` = 1.
- `dp_done` delayed 5 cycles and a second `tick` while busy:
  - Operands stay stable throughout, and the second tick is ignored with `overrun` = 1.
  - A `dp_done` in the ISSUE cycle is ignored.
- Assert `rst` while in WAIT for neuron 1:
  - `busy` = 0, and all `state_mem` entries are 0 on the next sweep.
  - A late `dp_done` causes no writeback and no spike.
